// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
// Module   : bcd_to_binary_seq
// Purpose  : Iterative BCD-to-binary converter (reverse double-dabble), one
//            shift per clock, with start/done handshake, digit validation and
//            range-overflow detection. Optional macro BCD2BIN_SAT_EN selects
//            saturation (all ones) instead of zero on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CMP_W = (ACC_W > BIN_W) ? ACC_W : BIN_W;
  localparam int CNT_W = $clog2(ACC_W);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ACC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ACC_W-1:0]   r_bcd;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin;
  logic               r_err;
  logic               r_ovf;

  logic [DIGITS-1:0]  w_bad;
  logic [2*ACC_W-1:0] w_shift;
  logic [ACC_W-1:0]   w_bcd_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CMP_W-1:0]   w_acc_ext;
  logic               w_ovf;
  logic [BIN_W-1:0]   w_bin_res;
  logic               w_last;

  assign w_shift   = {r_bcd, r_acc} >> 1;
  assign w_acc_nxt = w_shift[ACC_W-1:0];

  // Per-digit validity check and post-shift correction (nibble >= 8 loses 3).
  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    logic [3:0] w_nib;
    assign w_bad[g]              = (r_bcd[4*g +: 4] > 4'd9);
    assign w_nib                 = w_shift[ACC_W + 4*g +: 4];
    assign w_bcd_nxt[4*g +: 4]   = (w_nib >= 4'd8) ? (w_nib - 4'd3) : w_nib;
  end

  assign w_acc_ext = CMP_W'(w_acc_nxt);
  assign w_ovf     = |(w_acc_ext >> BIN_W);
  assign w_last    = (r_cnt == c_LAST);

`ifdef BCD2BIN_SAT_EN
  assign w_bin_res = w_ovf ? {BIN_W{1'b1}} : w_acc_ext[BIN_W-1:0];
`else
  assign w_bin_res = w_ovf ? {BIN_W{1'b0}} : w_acc_ext[BIN_W-1:0];
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = (|w_bad) ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // bin_out is only rewritten when a conversion finishes, so it holds across IDLE.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_bcd <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_bin <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bcd <= bcd_in;
            r_acc <= '0;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        S_CHECK: begin
          r_cnt <= '0;
          if (|w_bad) begin
            r_err <= 1'b1;
            r_ovf <= 1'b0;
            r_bin <= '0;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_bin <= w_bin_res;
            r_ovf <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bin_out = r_bin;
  assign err     = r_err;
  assign ovf     = r_ovf;
  assign busy    = (r_state == S_CHECK) || (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
// ============================================================================
// Module   : tb_bcd_to_binary_seq
// Purpose  : Self-checking bench for bcd_to_binary_seq (DIGITS=3, BIN_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 8;
  localparam int LAT_OK = 4 * DIGITS + 1;

  logic             clk = 1'b0;
  logic             res = 1'b1;
  logic             start = 1'b0;
  logic [11:0]      bcd_in = '0;
  logic [BIN_W-1:0] bin_out;
  logic             busy, done, err, ovf;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] sb[$];

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .res(res), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [11:0] b, output int lat);
    int v;
    logic [BIN_W-1:0] eb;
    logic ee, eo;
    ee = (b[3:0] > 9) || (b[7:4] > 9) || (b[11:8] > 9);
    v  = int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    eo = !ee && (v > 255);
`ifdef BCD2BIN_SAT_EN
    eb = ee ? 8'h00 : (eo ? 8'hFF : 8'(v));
`else
    eb = (ee || eo) ? 8'h00 : 8'(v);
`endif
    lat = ee ? 1 : LAT_OK;
    return {eb, ee, eo};
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      chk("spurious_done", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("bin_out", 32'(bin_out), 32'(e[9:2]));
        chk("err", 32'(err), 32'(e[1]));
        chk("ovf", 32'(ovf), 32'(e[0]));
      end
    end
    if (done && busy) chk("busy_and_done", 32'(busy & done), 32'd0);
  end

  // Drive one conversion; optionally pulse start with other data at edge inj_e.
  task automatic run(input logic [11:0] b, input int inj_e, input bit chk_busy);
    int exp_lat;
    int lat;
    sb.push_back(model(b, exp_lat));
    start  = 1'b1;
    bcd_in = b;
    lat    = -1;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      start  = (e == inj_e);
      bcd_in = (e == inj_e) ? 12'h777 : 12'($urandom);
      if (done) begin
        lat = e;
        break;
      end
      if (chk_busy) chk("busy_during_conv", 32'(busy), 32'd1);
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk("idle_after_done", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({bin_out, busy, done, err, ovf}), 32'd0);
    res = 1'b0;
    @(negedge clk);

    // Max in-range value
    run(12'h255, -1, 1'b1);
    // Overflow
    run(12'h999, -1, 1'b1);
    // Start during SHIFT is ignored
    run(12'h200, 5, 1'b0);
    repeat (20) @(negedge clk);

    // Reset while in SHIFT with cnt=5 (after edge 6)
    start  = 1'b1;
    bcd_in = 12'h255;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 res = 1'b1;
    #1 chk("midconv_reset", 32'({bin_out, busy, done, err, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    #2 res = 1'b0;
    repeat (16) @(negedge clk);
    run(12'h042, -1, 1'b1);

    // Invalid digit
    run(12'h1A3, -1, 1'b1);
    // Small values
    run(12'h100, -1, 1'b1);
    run(12'h000, -1, 1'b1);

    // Exhaustive valid sweep
    for (int v = 0; v < 1000; v++) begin
      logic [11:0] b;
      b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run(b, -1, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
